// File: rtl/dice_roll_capture_pkg.sv
// Shared types and constants for the dice-roll capture block.
package dice_roll_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLL    = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam logic [2:0] FACE_MIN = 3'd1;
  localparam logic [2:0] FACE_MAX = 3'd6;

  function automatic logic face_err(input logic [2:0] v);
    return (v < FACE_MIN) || (v > FACE_MAX);
  endfunction

endpackage

// File: rtl/dice_roll_capture_if.sv
// Valid/ready result slot carrying the captured face and its error flag.
interface dice_roll_capture_if;
  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_value;
  logic       res_err;

  modport master (output res_valid, output res_value, output res_err, input res_ready);
  modport slave  (input res_valid, input res_value, input res_err, output res_ready);
endinterface

// File: rtl/dice_roll_capture_btn_sync.sv
// Multi-stage synchroniser for the asynchronous roll button level.
module dice_roll_capture_btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/dice_roll_capture.sv
// Drives the dice counter enable, captures the settled face into a valid/ready slot,
// and keeps saturating roll statistics.
module dice_roll_capture
  import dice_roll_capture_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int SUM_W         = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_roll_btn,
  input  logic [2:0]           i_num_in,
  output logic                 o_cnt_en,
  dice_roll_capture_if.master  res_if,
  output logic                 o_overflow,
  input  logic                 i_clr_stats,
  output logic [CNT_W-1:0]     o_roll_count,
  output logic [SUM_W-1:0]     o_roll_sum
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (&a) ? a : a + CNT_W'(1);
  endfunction

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [2:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + (SUM_W+1)'(b);
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  state_t             r_state, w_state_nxt;
  logic [SET_W-1:0]   r_settle;
  logic               w_btn_s;
  logic               r_valid, r_err, r_ovf;
  logic [2:0]         r_value;
  logic [CNT_W-1:0]   r_cnt, w_cnt_base;
  logic [SUM_W-1:0]   r_sum, w_sum_base;
  logic               w_capture, w_load, w_drop, w_err;

  dice_roll_capture_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (i_roll_btn),
    .o_sync  (w_btn_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_btn_s)  w_state_nxt = ROLL;
      ROLL:    if (!w_btn_s) w_state_nxt = SETTLE;
      SETTLE:  if (r_settle == '0) w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Settle counter: loaded on release, counts down to zero while the counter output settles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 r_settle <= '0;
    else if (r_state == ROLL && !w_btn_s)         r_settle <= SETTLE_LOAD;
    else if (r_state == SETTLE && r_settle != '0) r_settle <= r_settle - SET_W'(1);
  end

  assign w_capture  = (r_state == CAPTURE);
  assign w_load     = w_capture && (!r_valid || res_if.res_ready);
  assign w_drop     = w_capture && r_valid && !res_if.res_ready;
  assign w_err      = face_err(i_num_in);
  assign w_cnt_base = i_clr_stats ? '0 : r_cnt;
  assign w_sum_base = i_clr_stats ? '0 : r_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_value <= '0;
      r_err   <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_value <= i_num_in;
      r_err   <= w_err;
    end else if (res_if.res_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Clear applies before this cycle's capture so a coinciding roll is still counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= (i_clr_stats ? 1'b0 : r_ovf) | w_drop;
      if (w_load && !w_err) begin
        r_cnt <= sat_inc(w_cnt_base);
        r_sum <= sat_add(w_sum_base, i_num_in);
      end else begin
        r_cnt <= w_cnt_base;
        r_sum <= w_sum_base;
      end
    end
  end

  assign o_cnt_en         = (r_state == ROLL);
  assign res_if.res_valid = r_valid;
  assign res_if.res_value = r_value;
  assign res_if.res_err   = r_err;
  assign o_overflow       = r_ovf;
  assign o_roll_count     = r_cnt;
  assign o_roll_sum       = r_sum;

endmodule

// File: tb/tb_dice_roll_capture.sv
// Scoreboard bench for dice_roll_capture: stimulus pushes expected results, a monitor pops on handshake.
module tb_dice_roll_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        roll_btn;
  logic        clr_stats;
  logic [2:0]  num_in;
  logic        cnt_en, overflow, cnt_en_s, overflow_s;
  logic [7:0]  roll_count;
  logic [11:0] roll_sum;
  logic [1:0]  count_s;
  logic [3:0]  sum_s;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  dice_roll_capture_if bus ();
  dice_roll_capture_if bus_s ();

  dice_roll_capture #(.SYNC_STAGES(2), .SETTLE_CYCLES(4), .CNT_W(8), .SUM_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .i_roll_btn(roll_btn), .i_num_in(num_in),
    .o_cnt_en(cnt_en), .res_if(bus), .o_overflow(overflow), .i_clr_stats(clr_stats),
    .o_roll_count(roll_count), .o_roll_sum(roll_sum)
  );

  dice_roll_capture #(.SYNC_STAGES(2), .SETTLE_CYCLES(4), .CNT_W(2), .SUM_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .i_roll_btn(roll_btn), .i_num_in(num_in),
    .o_cnt_en(cnt_en_s), .res_if(bus_s), .o_overflow(overflow_s), .i_clr_stats(clr_stats),
    .o_roll_count(count_s), .o_roll_sum(sum_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake is due at the next rising edge, so compare against the queue head.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got value=%0d err=%0d expected none", bus.res_value, bus.res_err);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("res_value", {29'd0, bus.res_value}, {29'd0, e[2:0]});
        check("res_err", {31'd0, bus.res_err}, {31'd0, e[3]});
      end
    end
  end

  task automatic apply_reset;
    reset_n       = 1'b0;
    roll_btn      = 1'b0;
    clr_stats     = 1'b0;
    num_in        = 3'd0;
    bus.res_ready = 1'b1;
    repeat (2) tick;
    reset_n = 1'b1;
    exp_q.delete();
    tick;
  endtask

  task automatic do_roll(input logic [2:0] v, input int hold,
                         output int n_valid, output int first_valid, output int n_en);
    num_in   = v;
    roll_btn = 1'b1;
    repeat (hold) tick;
    roll_btn    = 1'b0;
    n_valid     = 0;
    first_valid = 0;
    n_en        = 0;
    for (int i = 1; i <= 12; i++) begin
      tick;
      if (bus.res_valid === 1'b1) begin
        n_valid++;
        if (first_valid == 0) first_valid = i;
      end
      if (cnt_en === 1'b1) n_en++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nv, fv, ne;
    bus_s.res_ready = 1'b1;
    apply_reset;

    check("rst_cnt_en", cnt_en, 0);
    check("rst_valid", bus.res_valid, 0);
    check("rst_value", bus.res_value, 0);
    check("rst_err", bus.res_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", roll_count, 0);
    check("rst_sum", roll_sum, 0);

    // Test 1: face 0 is an error and is not counted
    exp_q.push_back({1'b1, 3'd0});
    do_roll(3'd0, 10, nv, fv, ne);
    check("t1_count", roll_count, 0);
    check("t1_sum", roll_sum, 0);

    // Test 2: single result, latency and enable window
    apply_reset;
    exp_q.push_back({1'b0, 3'd5});
    num_in   = 3'd5;
    roll_btn = 1'b1;
    repeat (6) tick;
    check("t2_en_hold", cnt_en, 1);
    roll_btn = 1'b0;
    nv = 0; fv = 0; ne = 0;
    for (int i = 1; i <= 12; i++) begin
      tick;
      if (bus.res_valid === 1'b1) begin
        nv++;
        if (fv == 0) fv = i;
      end
      if (cnt_en === 1'b1) ne++;
    end
    check("t2_valid_cycles", nv, 1);
    check("t2_latency", fv, 8);
    check("t2_en_after_release", ne, 2);
    check("t2_count", roll_count, 1);
    check("t2_sum", roll_sum, 5);

    // Test 3: full slot drops the second capture
    apply_reset;
    bus.res_ready = 1'b0;
    exp_q.push_back({1'b0, 3'd3});
    do_roll(3'd3, 6, nv, fv, ne);
    check("t3_valid_held", nv, 5);
    do_roll(3'd4, 6, nv, fv, ne);
    check("t3_value_kept", bus.res_value, 3);
    check("t3_overflow", overflow, 1);
    check("t3_count", roll_count, 1);
    check("t3_sum", roll_sum, 3);
    clr_stats = 1'b1;
    tick;
    clr_stats = 1'b0;
    check("t3_clr_overflow", overflow, 0);
    check("t3_clr_count", roll_count, 0);
    check("t3_clr_sum", roll_sum, 0);
    bus.res_ready = 1'b1;
    repeat (2) tick;
    check("t3_drained", bus.res_valid, 0);

    // Test 4: saturation on the narrow instance
    apply_reset;
    for (int r = 0; r < 5; r++) begin
      exp_q.push_back({1'b0, 3'd6});
      do_roll(3'd6, 6, nv, fv, ne);
    end
    check("t4_count", roll_count, 5);
    check("t4_sum", roll_sum, 30);
    check("t4_sat_count", count_s, 3);
    check("t4_sat_sum", sum_s, 15);

    // Test 5: button held through settle, then reset during ROLL
    apply_reset;
    bus.res_ready = 1'b0;
    num_in   = 3'd2;
    roll_btn = 1'b1;
    repeat (6) tick;
    roll_btn = 1'b0;
    tick;
    roll_btn = 1'b1;
    repeat (7) tick;
    check("t5_valid", bus.res_valid, 1);
    check("t5_value", bus.res_value, 2);
    check("t5_idle_en", cnt_en, 0);
    tick;
    check("t5_reroll_en", cnt_en, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_en", cnt_en, 0);
    check("t5_rst_valid", bus.res_valid, 0);
    roll_btn = 1'b0;
    repeat (2) tick;
    reset_n       = 1'b1;
    bus.res_ready = 1'b1;
    exp_q.delete();
    tick;

    // Test 6: handshake, capture and clear in the same cycle
    apply_reset;
    bus.res_ready = 1'b0;
    exp_q.push_back({1'b0, 3'd1});
    do_roll(3'd1, 6, nv, fv, ne);
    check("t6_count_a", roll_count, 1);
    check("t6_sum_a", roll_sum, 1);
    exp_q.push_back({1'b0, 3'd2});
    num_in   = 3'd2;
    roll_btn = 1'b1;
    repeat (6) tick;
    roll_btn = 1'b0;
    repeat (7) tick;
    bus.res_ready = 1'b1;
    clr_stats     = 1'b1;
    tick;
    clr_stats = 1'b0;
    check("t6_valid", bus.res_valid, 1);
    check("t6_value", bus.res_value, 2);
    check("t6_overflow", overflow, 0);
    check("t6_count", roll_count, 1);
    check("t6_sum", roll_sum, 2);
    repeat (3) tick;

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
